bcd_convert: RTL and testbench



---
 rtl/bcd_convert.sv | 87 ++++++++
 tb/tb_bcd_convert.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bcd_convert.sv
// bcd_convert: sequential double-dabble binary-to-BCD converter, one bit per clock, 8 packed digits.
// Optional macro BCD_BLANK_EN replaces leading zero digits with 4'hF (segments off).
module bcd_convert #(
   parameter int WIDTH = 27
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [31:0]      data,
   output logic             ovf
);
`ifdef BCD_BLANK_EN
   localparam logic [31:0] RST_DATA = 32'hFFFF_FFF0;
`else
   localparam logic [31:0] RST_DATA = 32'h0000_0000;
`endif
   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] sr;
   logic [31:0]      acc, adj, res, bin_x;
   logic [4:0]       cnt;
   logic             ovf_f;
   assign bin_x = 32'(bin);
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? SHIFT : IDLE;
         SHIFT:   state_n = (cnt == 5'd1) ? FINISH : SHIFT;
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      adj = acc;
      for (int i = 0; i < 8; i++)
         adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
   end
`ifdef BCD_BLANK_EN
   logic lead;
   // blank every zero digit above the most significant nonzero one; digit 0 always shown
   always_comb begin
      res  = acc;
      lead = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         if (lead && acc[4*i +: 4] == 4'h0) res[4*i +: 4] = 4'hF;
         else lead = 1'b0;
      end
   end
`else
   assign res = acc;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sr    <= '0;
         acc   <= '0;
         cnt   <= '0;
         ovf_f <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
         data  <= RST_DATA;
      end else begin
         state <= state_n;
         busy  <= state_n != IDLE;
         done  <= state == FINISH;
         case (state)
            IDLE: if (start) begin
               sr    <= bin;
               acc   <= '0;
               cnt   <= 5'(WIDTH);
               ovf_f <= bin_x > 32'd99_999_999;
            end
            SHIFT: begin
               {acc, sr} <= {adj, sr} << 1;
               cnt       <= cnt - 5'd1;
            end
            default: begin
               data <= ovf_f ? 32'h9999_9999 : res;
               ovf  <= ovf_f;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_convert.sv
// tb_bcd_convert: scoreboard bench for bcd_convert; directed vectors, monitor pops on done.
module tb_bcd_convert;
`ifdef BCD_BLANK_EN
   localparam logic BL = 1'b1;
`else
   localparam logic BL = 1'b0;
`endif
   localparam logic [31:0] RST = BL ? 32'hFFFF_FFF0 : 32'h0000_0000;
   logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0;
   logic [26:0] bin = '0;
   logic        busy, done, ovf;
   logic [31:0] data, prev;
   logic [32:0] sb[$];
   int          n_chk = 0, n_pass = 0;
   bcd_convert #(.WIDTH(27)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy), .done(done), .data(data), .ovf(ovf)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   always @(negedge clk) begin
      logic [32:0] e;
      if (!rst_n) prev = RST;
      else if (done) begin
         if (sb.size() == 0) chk("done_with_empty_scoreboard", 32'(sb.size()), 32'd1);
         else begin
            e = sb.pop_front();
            chk("data", data, e[31:0]);
            chk("ovf", 32'(ovf), 32'(e[32]));
         end
         prev = data;
      end else chk("data_stable", data, prev);
   end
   task automatic wait_done(output int cyc, output int nb);
      cyc = 0;
      nb  = busy ? 1 : 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (busy) nb++;
      end
   endtask
   task automatic run(input logic [26:0] v, input logic [31:0] ed, input logic eo);
      int cyc, nb;
      @(negedge clk);
      start = 1'b1;
      bin   = v;
      sb.push_back({eo, ed});
      @(negedge clk);
      start = 1'b0;
      bin   = 27'h5A5_A5A5;
      wait_done(cyc, nb);
      chk("latency", 32'(cyc), 32'd28);
      chk("busy_cycles", 32'(nb), 32'd28);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
   endtask
   initial begin
      int cyc, nb, nd;
      int d[3];
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", data, RST);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      run(27'd12_345_678, 32'h1234_5678, 1'b0);
      run(27'd405, BL ? 32'hFFFF_F405 : 32'h0000_0405, 1'b0);
      run(27'd0, RST, 1'b0);
      run(27'd7, BL ? 32'hFFFF_FFF7 : 32'h0000_0007, 1'b0);
      run(27'd10_000_000, 32'h1000_0000, 1'b0);
      run(27'd99_999_999, 32'h9999_9999, 1'b0);
      run(27'd100_000_000, 32'h9999_9999, 1'b1);
      run(27'h7FF_FFFF, 32'h9999_9999, 1'b1);
      run(27'd2_024, BL ? 32'hFFFF_2024 : 32'h0000_2024, 1'b0);
      // extra start at E5 must be dropped
      @(negedge clk);
      start = 1'b1;
      bin   = 27'd12_345_678;
      sb.push_back({1'b0, 32'h1234_5678});
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      bin   = 27'd87_654_321;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, nb);
      chk("ignored_start_latency", 32'(cyc), 32'd23);
      repeat (35) @(negedge clk);
      chk("ignored_start_idle", 32'(busy), 32'd0);
      // start held high across three accepts
      @(negedge clk);
      start = 1'b1;
      bin   = 27'd777;
      repeat (3) sb.push_back({1'b0, BL ? 32'hFFFF_F777 : 32'h0000_0777});
      @(negedge clk);
      nd = 0;
      for (int k = 0; k <= 90; k++) begin
         if (done && nd < 3) begin
            d[nd] = k;
            nd++;
         end
         if (k == 58) start = 1'b0;
         @(negedge clk);
      end
      chk("held_done_count", 32'(nd), 32'd3);
      chk("held_done_0", 32'(d[0]), 32'd28);
      chk("held_done_1", 32'(d[1]), 32'd57);
      chk("held_done_2", 32'(d[2]), 32'd86);
      // asynchronous reset at E10 of a conversion
      @(negedge clk);
      start = 1'b1;
      bin   = 27'd87_654_321;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_data", data, RST);
      chk("midrst_done", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_idle", 32'(busy), 32'd0);
      run(27'd12_345_678, 32'h1234_5678, 1'b0);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
